// File: rtl/gf2m_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gf2m_pkg
// Purpose : Shared definitions for the GF(2^m) squaring sequencer: command
//           code, FSM state encoding and the source word / half-word count
//           derivations.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package gf2m_pkg;

  localparam logic [3:0] CMD_SQR = 4'h2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_RED   = 3'd4,
    ST_DONE  = 3'd5
  } sqr_state_e;

  // Number of source words covering a degree-len polynomial.
  // lg_word is log2 of the word width (word width is a power of two).
  function automatic logic [31:0] calc_n(input logic [31:0] len, input int lg_word);
    return (len >> lg_word) + 32'd1;
  endfunction

  // Number of half-words; each source half-word expands to one full
  // destination word after squaring (bits are interleaved with zeros).
  function automatic logic [31:0] calc_h(input logic [31:0] len, input int lg_word);
    return (len >> (lg_word - 1)) + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf2m_sqr_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : gf2m_sqr_addr_gen
// Purpose : Combinational address / bank-select generator. Given the current
//           half-word index (as word offset + odd flag) and the phase of the
//           sequencer, produces the source read address and half select and
//           the destination bank enables and addresses.
// Ports   : i_rd, i_wr        - sequencer is in the read / write phase
//           i_h_odd           - bit 0 of the half-word index h
//           i_word            - h >> 1, already wrapped to ADDR_W bits
//           i_src_base        - start_addr - N, latched at start
//           i_dst_base        - dst_addr, latched at start
//           o_addr_a, o_byte_pos_a       - source address / half select
//           o_w_c, o_addr_c, o_w_d, o_addr_d - bank C / D write port
// Rev     : 1.0  initial release
// ============================================================================
module gf2m_sqr_addr_gen #(
  parameter int ADDR_W = 3
) (
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic              i_h_odd,
  input  logic [ADDR_W-1:0] i_word,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  output logic [ADDR_W-1:0] o_addr_a,
  output logic              o_byte_pos_a,
  output logic              o_w_c,
  output logic [ADDR_W-1:0] o_addr_c,
  output logic              o_w_d,
  output logic [ADDR_W-1:0] o_addr_d
);

  logic [ADDR_W-1:0] w_src_addr;
  logic [ADDR_W-1:0] w_dst_addr;

  // Natural ADDR_W-bit wrap on both sums.
  assign w_src_addr = i_src_base + i_word;
  assign w_dst_addr = i_dst_base + i_word;

  // Addresses are forced to zero outside their active phase so the bus is
  // quiet in IDLE/SETUP/RED/DONE and after reset.
  assign o_addr_a     = i_rd ? w_src_addr : '0;
  assign o_byte_pos_a = i_rd & i_h_odd;

  // Even half-words land in bank C, odd ones in bank D.
  assign o_w_c    = i_wr & ~i_h_odd;
  assign o_w_d    = i_wr &  i_h_odd;
  assign o_addr_c = o_w_c ? w_dst_addr : '0;
  assign o_addr_d = o_w_d ? w_dst_addr : '0;

endmodule
`default_nettype wire

// File: rtl/gf2m_square_seq.sv
`default_nettype none
// ============================================================================
// Module  : gf2m_square_seq
// Purpose : Sequencer for GF(2^m) polynomial squaring. Walks the source
//           polynomial half-word by half-word (read, then write to bank C for
//           even / bank D for odd half-words), optionally hands the result to
//           an external reducer and repeats.
// Config  : `define SQR_REPEAT_EN  - run max(rep_cnt,1) passes with a reducer
//           handshake (red_req / red_done) between passes. Without it a
//           single pass runs, rep_cnt/red_done are ignored, red_req is 0.
// Ports   : clk, rst (sync, active high)
//           command, start_addr, dst_addr, Data_len_Polynomial, rep_cnt
//           b_adbus_A, byte_pos_A        - source read port
//           b_w_C, b_adbus_C, b_w_D, b_adbus_D - destination banks
//           red_req / red_done           - reducer handshake
//           cmd_sqr (busy), interupt (completion pulse)
// Rev     : 1.0  initial release
// ============================================================================
module gf2m_square_seq #(
  parameter int ADDR_W = 3,
  parameter int LEN_W  = 10,
  parameter int WORD_W = 256,
  parameter int REP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        command,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  Data_len_Polynomial,
  input  logic [REP_W-1:0]  rep_cnt,
  output logic [ADDR_W-1:0] b_adbus_A,
  output logic              byte_pos_A,
  output logic              b_w_C,
  output logic [ADDR_W-1:0] b_adbus_C,
  output logic              b_w_D,
  output logic [ADDR_W-1:0] b_adbus_D,
  output logic              red_req,
  input  logic              red_done,
  output logic              cmd_sqr,
  output logic              interupt
);

  import gf2m_pkg::*;

  localparam int LG_W = $clog2(WORD_W);

  sqr_state_e        r_state;
  logic [ADDR_W-1:0] r_src_base;
  logic [ADDR_W-1:0] r_dst_base;
  logic [LEN_W-1:0]  r_h_last;   // H - 1
  logic [LEN_W-1:0]  r_h;        // current half-word index
  logic [ADDR_W-1:0] r_word;     // h >> 1, wrapped to the address width

  logic [ADDR_W-1:0] w_n;
  logic [LEN_W-1:0]  w_h_last;
  logic              w_last_half;

  assign w_n         = ADDR_W'(calc_n(32'(Data_len_Polynomial), LG_W));
  assign w_h_last    = LEN_W'(calc_h(32'(Data_len_Polynomial), LG_W) - 32'd1);
  assign w_last_half = (r_h == r_h_last);

`ifdef SQR_REPEAT_EN
  logic [REP_W-1:0] r_pass;
  logic [REP_W-1:0] r_pass_last;
  logic             r_red_req;
  logic [REP_W-1:0] w_pass_last;

  // rep_cnt of 0 runs a single pass, same as 1.
  assign w_pass_last = (rep_cnt == '0) ? '0 : rep_cnt - REP_W'(1);
  assign red_req     = r_red_req;
`else
  logic w_unused_rep;
  assign w_unused_rep = ^{rep_cnt, red_done};
  assign red_req      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_src_base <= '0;
      r_dst_base <= '0;
      r_h_last   <= '0;
      r_h        <= '0;
      r_word     <= '0;
`ifdef SQR_REPEAT_EN
      r_pass      <= '0;
      r_pass_last <= '0;
      r_red_req   <= 1'b0;
`endif
    end else begin
`ifdef SQR_REPEAT_EN
      r_red_req <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (command == CMD_SQR) begin
            r_state    <= ST_SETUP;
            r_src_base <= start_addr - w_n;
            r_dst_base <= dst_addr;
            r_h_last   <= w_h_last;
            r_h        <= '0;
            r_word     <= '0;
`ifdef SQR_REPEAT_EN
            r_pass      <= '0;
            r_pass_last <= w_pass_last;
`endif
          end
        end
        ST_SETUP: r_state <= ST_RD;
        ST_RD:    r_state <= ST_WR;
        ST_WR: begin
          if (!w_last_half) begin
            r_h     <= r_h + LEN_W'(1);
            // Word offset advances after the high half of each word.
            if (r_h[0]) begin
              r_word <= r_word + ADDR_W'(1);
            end
            r_state <= ST_RD;
          end else begin
`ifdef SQR_REPEAT_EN
            if (r_pass != r_pass_last) begin
              r_pass    <= r_pass + REP_W'(1);
              r_h       <= '0;
              r_word    <= '0;
              r_red_req <= 1'b1;
              r_state   <= ST_RED;
            end else begin
              r_state <= ST_DONE;
            end
`else
            r_state <= ST_DONE;
`endif
          end
        end
        ST_RED: begin
          // Only reachable with repeat enabled; red_done is looked at here
          // and nowhere else.
          if (red_done) begin
            r_state <= ST_RD;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_sqr  = (r_state != ST_IDLE);
  assign interupt = (r_state == ST_DONE);

  gf2m_sqr_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_rd         (r_state == ST_RD),
    .i_wr         (r_state == ST_WR),
    .i_h_odd      (r_h[0]),
    .i_word       (r_word),
    .i_src_base   (r_src_base),
    .i_dst_base   (r_dst_base),
    .o_addr_a     (b_adbus_A),
    .o_byte_pos_a (byte_pos_A),
    .o_w_c        (b_w_C),
    .o_addr_c     (b_adbus_C),
    .o_w_d        (b_w_D),
    .o_addr_d     (b_adbus_D)
  );

endmodule
`default_nettype wire

// File: tb/tb_gf2m_square_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_gf2m_square_seq
// Purpose : Directed self-checking bench for gf2m_square_seq with default
//           parameters (ADDR_W=3, LEN_W=10, WORD_W=256, REP_W=4). Expected
//           read/write schedules are hand-computed tables.
// Rev     : 1.0  initial release
// ============================================================================
module tb_gf2m_square_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] command;
  logic [2:0] start_addr;
  logic [2:0] dst_addr;
  logic [9:0] Data_len_Polynomial;
  logic [3:0] rep_cnt;
  logic [2:0] b_adbus_A;
  logic       byte_pos_A;
  logic       b_w_C;
  logic [2:0] b_adbus_C;
  logic       b_w_D;
  logic [2:0] b_adbus_D;
  logic       red_req;
  logic       red_done;
  logic       cmd_sqr;
  logic       interupt;

  int n_total = 0;
  int n_bad   = 0;

  logic [2:0] exp_ra[8];
  bit         exp_rh[8];
  bit         exp_wb[8];   // 0 = bank C, 1 = bank D
  logic [2:0] exp_wa[8];

  always #5 clk = ~clk;

  gf2m_square_seq dut (
    .clk                 (clk),
    .rst                 (rst),
    .command             (command),
    .start_addr          (start_addr),
    .dst_addr            (dst_addr),
    .Data_len_Polynomial (Data_len_Polynomial),
    .rep_cnt             (rep_cnt),
    .b_adbus_A           (b_adbus_A),
    .byte_pos_A          (byte_pos_A),
    .b_w_C               (b_w_C),
    .b_adbus_C           (b_adbus_C),
    .b_w_D               (b_w_D),
    .b_adbus_D           (b_adbus_D),
    .red_req             (red_req),
    .red_done            (red_done),
    .cmd_sqr             (cmd_sqr),
    .interupt            (interupt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {cmd_sqr, interupt, red_req, w_C, w_D, byte_pos, adA, adC, adD}
  function automatic logic [31:0] obs();
    return {17'd0, cmd_sqr, interupt, red_req, b_w_C, b_w_D, byte_pos_A,
            b_adbus_A, b_adbus_C, b_adbus_D};
  endfunction

  function automatic logic [31:0] mk(bit cs, bit it, bit wc, bit wd, bit bp,
                                     logic [2:0] ra, logic [2:0] ac, logic [2:0] ad);
    return {17'd0, cs, it, 1'b0, wc, wd, bp, ra, ac, ad};
  endfunction

  // Start one operation and check every cycle against the expected tables.
  // k = number of edges after the start edge.
  task automatic run_op(input string name, input logic [2:0] sa, input logic [2:0] da,
                        input logic [9:0] len, input int hh, input bit busy_cmd,
                        input int abort_k);
    logic [31:0] e;
    int h;
    int bad;
    bit cs, it, wc, wd, bp;
    logic [2:0] ra, ac, ad;
    @(negedge clk);
    command = 4'h2; start_addr = sa; dst_addr = da; Data_len_Polynomial = len;
    for (int k = 0; k <= 2*hh + 2; k++) begin
      @(negedge clk);
      cs = (k <= 2*hh + 1); it = (k == 2*hh + 1);
      wc = 0; wd = 0; bp = 0; ra = 0; ac = 0; ad = 0;
      if ((k % 2 == 1) && (k <= 2*hh - 1)) begin
        h = (k - 1) / 2; ra = exp_ra[h]; bp = exp_rh[h];
      end
      if ((k % 2 == 0) && (k >= 2) && (k <= 2*hh)) begin
        h = k / 2 - 1;
        if (exp_wb[h]) begin wd = 1; ad = exp_wa[h]; end
        else begin wc = 1; ac = exp_wa[h]; end
      end
      e = mk(cs, it, wc, wd, bp, ra, ac, ad);
      check($sformatf("%s_k%0d", name, k), obs(), e);
      command = (busy_cmd && k < 6) ? 4'h2 : 4'h0;
      if (k == abort_k) begin
        rst = 1'b1;
        @(negedge clk);
        check({name, "_abort_zero"}, obs(), 32'd0);
        rst = 1'b0;
        bad = 0;
        repeat (16) begin
          @(negedge clk);
          if (obs() != 32'd0) bad++;
        end
        check({name, "_abort_quiet"}, bad, 0);
        return;
      end
    end
  endtask

`ifdef SQR_REPEAT_EN
  task automatic run_rep(input string name, input logic [3:0] rc,
                         input int exp_red, input int exp_wr);
    int n_red, n_wr, n_int, cyc, done_at;
    bit fin;
    n_red = 0; n_wr = 0; n_int = 0; cyc = 0; done_at = -1; fin = 0;
    @(negedge clk);
    rep_cnt = rc; command = 4'h2; start_addr = 3'd0; dst_addr = 3'd0;
    Data_len_Polynomial = 10'd128;
    @(negedge clk);
    command = 4'h0;
    while (!fin && cyc < 300) begin
      red_done = (cyc == done_at);
      if (red_req) begin n_red++; done_at = cyc + 5; end
      if (b_w_C) n_wr++;
      if (b_w_D) n_wr++;
      if (interupt) n_int++;
      if (n_int > 0 && !cmd_sqr) fin = 1;
      @(negedge clk);
      cyc++;
    end
    red_done = 1'b0;
    rep_cnt = 4'd0;
    check({name, "_finished"}, 32'(fin), 32'd1);
    check({name, "_red_pulses"}, n_red, exp_red);
    check({name, "_writes"}, n_wr, exp_wr);
    check({name, "_interupts"}, n_int, 1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; command = 4'h0; start_addr = 3'd0; dst_addr = 3'd0;
    Data_len_Polynomial = 10'd0; rep_cnt = 4'd0; red_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", obs(), 32'd0);
    rst = 1'b0;

    // Non-squaring command in IDLE, plus a stray red_done: nothing happens.
    command = 4'h3; red_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("idle_cmd3_%0d", i), obs(), 32'd0);
    end
    command = 4'h0; red_done = 1'b0;

    // Scenario 1: start 5, dst 0, L=570 -> N=3, H=5.
    exp_ra = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0};
    exp_rh = '{0, 1, 0, 1, 0, 0, 0, 0};
    exp_wb = '{0, 1, 0, 1, 0, 0, 0, 0};
    exp_wa = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0};
    run_op("s1", 3'd5, 3'd0, 10'd570, 5, 1'b0, -1);

    // Scenario 3: re-issue CMD_SQR while busy -> same schedule, no restart.
    run_op("s3", 3'd5, 3'd0, 10'd570, 5, 1'b1, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("s3_norestart_%0d", i), obs(), 32'd0);
    end

    // Scenario 4: reset at the third write (k=6), then a fresh run.
    run_op("s4", 3'd5, 3'd0, 10'd570, 5, 1'b0, 6);
    run_op("s4_fresh", 3'd5, 3'd0, 10'd570, 5, 1'b0, -1);

    // Scenario 2: L=100 -> N=1, H=1. rep_cnt is ignored without repeat.
    exp_ra = '{3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    exp_rh = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_wb = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_wa = '{3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`ifndef SQR_REPEAT_EN
    rep_cnt = 4'd3;
`endif
    run_op("s2", 3'd5, 3'd2, 10'd100, 1, 1'b0, -1);
    rep_cnt = 4'd0;

    // Scenario 6: start 1 -> source addresses wrap to 6,6,7,7,0; dst 3.
    exp_ra = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0};
    exp_rh = '{0, 1, 0, 1, 0, 0, 0, 0};
    exp_wb = '{0, 1, 0, 1, 0, 0, 0, 0};
    exp_wa = '{3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0};
    run_op("s6", 3'd1, 3'd3, 10'd570, 5, 1'b0, -1);

    // L=127: last length with H=1; start 0 wraps read to 7.
    exp_ra = '{3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    exp_rh = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_wb = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_wa = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    run_op("l127", 3'd0, 3'd0, 10'd127, 1, 1'b0, -1);

    // L=128: N=1, H=2 -> both halves of word 7, C@7 and D@7.
    exp_ra = '{3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    exp_rh = '{0, 1, 0, 0, 0, 0, 0, 0};
    exp_wb = '{0, 1, 0, 0, 0, 0, 0, 0};
    exp_wa = '{3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    run_op("l128", 3'd0, 3'd7, 10'd128, 2, 1'b0, -1);

    // L=256: N=2, H=3; start 2 -> base 0; dst 7 wraps to 0 on third write.
    exp_ra = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    exp_rh = '{0, 1, 0, 0, 0, 0, 0, 0};
    exp_wb = '{0, 1, 0, 0, 0, 0, 0, 0};
    exp_wa = '{3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    run_op("l256", 3'd2, 3'd7, 10'd256, 3, 1'b0, -1);

`ifdef SQR_REPEAT_EN
    // Scenario 5: L=128 (H=2). rep 3 -> 2 reducer handshakes, 6 writes.
    run_rep("s5_rep3", 4'd3, 2, 6);
    run_rep("s5_rep0", 4'd0, 0, 2);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
